// File: rtl/ram_dist_pkg.sv
// Shared types and sizing helpers for the distributed dual-port RAM.
package ram_dist_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_dist_core.sv
// Bare LUT array: one synchronous write port, two asynchronous read ports, no reset.
module ram_dist_core
  import ram_dist_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int DEPTH = depth_of(ADDR_W);

  // Declaration initialiser sets the FPGA power-up contents.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_VAL};

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/ram_dist_dp.sv
// Dual-port distributed RAM with clear sequencer, optional registered reads and
// write-collision bypass. User writes are discarded (WE_DROP) while a sweep runs.
module ram_dist_dp
  import ram_dist_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 5,
  parameter int                OUT_REG  = 0,
  parameter int                WR_FIRST = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] DPRA,
  output logic [DATA_W-1:0] SPO,
  output logic [DATA_W-1:0] DPO,
  output logic              BUSY,
  output logic              WE_DROP
);

  localparam int                DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              we_drop_q, we_drop_d;
  logic [DATA_W-1:0] spo_q, spo_d, dpo_q, dpo_d;

  logic              busy, user_we, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_a, mem_b;

  assign busy      = (state_q == ST_CLEAR);
  assign user_we   = WE & ~busy & ~CLR;
  assign mem_we    = busy | user_we;
  assign mem_waddr = busy ? clr_cnt_q : A;
  assign mem_wdata = busy ? INIT_VAL : D;

  ram_dist_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INIT_VAL(INIT_VAL)
  ) u_core (
    .clk_i    (CLK),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (mem_wdata),
    .raddr_a_i(A),
    .raddr_b_i(DPRA),
    .rdata_a_o(mem_a),
    .rdata_b_o(mem_b)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (CLR) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (CLR) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == LAST) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // The sweep write obeys the same read/write collision rule as a user write.
  always_comb begin
    we_drop_d = WE & (busy | CLR);
    spo_d     = (mem_we && (mem_waddr == A)    && (WR_FIRST != 0)) ? mem_wdata : mem_a;
    dpo_d     = (mem_we && (mem_waddr == DPRA) && (WR_FIRST != 0)) ? mem_wdata : mem_b;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      we_drop_q <= 1'b0;
      spo_q     <= '0;
      dpo_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      we_drop_q <= we_drop_d;
      spo_q     <= spo_d;
      dpo_q     <= dpo_d;
    end
  end

  assign SPO     = (OUT_REG != 0) ? spo_q : mem_a;
  assign DPO     = (OUT_REG != 0) ? dpo_q : mem_b;
  assign BUSY    = busy;
  assign WE_DROP = we_drop_q;

endmodule

// File: tb/tb_ram_dist_dp.sv
// Bench for ram_dist_dp: async, registered read-first and registered write-first
// instances share one stimulus stream and are checked against hand-computed vectors.
module tb_ram_dist_dp;

  logic       CLK, RST, CLR, WE;
  logic [2:0] A, DPRA;
  logic [7:0] D;

  logic [7:0] spo0, dpo0, spo1, dpo1, spo2, dpo2;
  logic       busy0, busy1, busy2, drop0, drop1, drop2;

  int n_chk  = 0;
  int n_fail = 0;

  ram_dist_dp #(.DATA_W(8), .ADDR_W(3), .OUT_REG(0), .WR_FIRST(0), .INIT_VAL(8'hA5)) u0 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WE(WE), .A(A), .D(D), .DPRA(DPRA),
    .SPO(spo0), .DPO(dpo0), .BUSY(busy0), .WE_DROP(drop0)
  );
  ram_dist_dp #(.DATA_W(8), .ADDR_W(3), .OUT_REG(1), .WR_FIRST(0), .INIT_VAL(8'hA5)) u1 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WE(WE), .A(A), .D(D), .DPRA(DPRA),
    .SPO(spo1), .DPO(dpo1), .BUSY(busy1), .WE_DROP(drop1)
  );
  ram_dist_dp #(.DATA_W(8), .ADDR_W(3), .OUT_REG(1), .WR_FIRST(1), .INIT_VAL(8'hA5)) u2 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .WE(WE), .A(A), .D(D), .DPRA(DPRA),
    .SPO(spo2), .DPO(dpo2), .BUSY(busy2), .WE_DROP(drop2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic       clr;
    logic [2:0] a;
    logic [2:0] dpra;
    logic [7:0] d;
    logic [7:0] spo0;
    logic [7:0] dpo0;
    logic [7:0] spo1;
    logic [7:0] dpo1;
    logic [7:0] dpo2;
    logic       busy;
    logic       drop;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic clr, input logic [2:0] a,
                      input logic [2:0] dpra, input logic [7:0] d);
    WE = we; CLR = clr; A = a; DPRA = dpra; D = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic rd0(input logic [2:0] addr, input logic [7:0] exp, input string name);
    WE = 1'b0; CLR = 1'b0; DPRA = addr;
    #1;
    chk(name, dpo0, exp);
  endtask

  // Counts edges until BUSY falls, giving up after 40.
  task automatic count_busy(output int n);
    n = 0;
    WE = 1'b0; CLR = 1'b0;
    while (busy0 && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_busy"}, {7'd0, busy0}, 8'd1);
    chk({name, "_drop"}, {7'd0, drop0}, 8'd0);
    chk({name, "_spo1"}, spo1, 8'h00);
    chk({name, "_dpo1"}, dpo1, 8'h00);
    chk({name, "_spo2"}, spo2, 8'h00);
    chk({name, "_dpo2"}, dpo2, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;

    //               we    clr   a     dpra  d        spo0   dpo0   spo1   dpo1   dpo2   busy  drop
    vecs[0]  = '{1'b1, 1'b0, 3'd5, 3'd5, 8'h3C, 8'h3C, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 3'd5, 3'd5, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'd2, 3'd2, 8'h11, 8'h11, 8'h11, 8'hA5, 8'hA5, 8'h11, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'd2, 3'd2, 8'h22, 8'h22, 8'h22, 8'h11, 8'h11, 8'h22, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 3'd2, 3'd2, 8'h00, 8'h22, 8'h22, 8'h22, 8'h22, 8'h22, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'd7, 3'd0, 8'h77, 8'h77, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 3'd7, 8'h0F, 8'h0F, 8'h77, 8'hA5, 8'h77, 8'h77, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 3'd7, 3'd0, 8'h00, 8'h77, 8'h0F, 8'h77, 8'h0F, 8'h0F, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'd3, 3'd3, 8'hEE, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'd4, 3'd0, 8'h44, 8'hA5, 8'hA5, 8'hA5, 8'h0F, 8'hA5, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 3'd7, 3'd1, 8'h00, 8'h77, 8'hA5, 8'h77, 8'hA5, 8'hA5, 1'b1, 1'b0};

    RST = 1'b1; CLR = 1'b0; WE = 1'b0; A = '0; DPRA = '0; D = '0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk_reset("rst");

    RST = 1'b0;
    count_busy(n);
    chk("rst_sweep_len", 8'(n), 8'd8);
    for (int i = 0; i < 8; i++) begin
      rd0(3'(i), 8'hA5, $sformatf("init_word%0d", i));
    end

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].we, vecs[i].clr, vecs[i].a, vecs[i].dpra, vecs[i].d);
      chk($sformatf("v%0d_spo0", i), spo0, vecs[i].spo0);
      chk($sformatf("v%0d_dpo0", i), dpo0, vecs[i].dpo0);
      chk($sformatf("v%0d_spo1", i), spo1, vecs[i].spo1);
      chk($sformatf("v%0d_dpo1", i), dpo1, vecs[i].dpo1);
      chk($sformatf("v%0d_dpo2", i), dpo2, vecs[i].dpo2);
      chk($sformatf("v%0d_busy", i), {7'd0, busy0}, {7'd0, vecs[i].busy});
      chk($sformatf("v%0d_drop", i), {7'd0, drop0}, {7'd0, vecs[i].drop});
    end

    // Sweep counter is now 2; advance to 4 and restart it with CLR.
    step(1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
    step(1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
    step(1'b0, 1'b1, 3'd0, 3'd0, 8'h00);
    chk("clr_restart_busy", {7'd0, busy0}, 8'd1);
    count_busy(n);
    chk("clr_restart_len", 8'(n), 8'd8);
    rd0(3'd7, 8'hA5, "cleared_w7");
    rd0(3'd5, 8'hA5, "cleared_w5");
    rd0(3'd2, 8'hA5, "cleared_w2");
    rd0(3'd3, 8'hA5, "dropped_w3");

    step(1'b1, 1'b0, 3'd6, 3'd6, 8'h66);
    chk("w6_spo0", spo0, 8'h66);
    step(1'b0, 1'b1, 3'd0, 3'd0, 8'h00);
    step(1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
    step(1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
    step(1'b0, 1'b0, 3'd0, 3'd0, 8'h00);
    RST = 1'b1;
    #1;
    chk_reset("mid_rst");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    count_busy(n);
    chk("mid_rst_sweep_len", 8'(n), 8'd8);
    rd0(3'd6, 8'hA5, "mid_rst_w6");
    chk("mid_rst_drop", {7'd0, drop0}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_dist_dp.md
# ram_dist_dp

Parametrised dual-port distributed (LUT) RAM, the generalised successor of the fixed 32x1 dual-port primitive model. It provides one read/write port and one read-only port with configurable data width and depth, an optional output register stage, and a built-in clear sequencer. The sequencer sweeps every word to `INIT_VAL` after reset or on request, because LUT storage cannot be reset directly. It is used for register files, small FIFOs and lookup tables in Verilator-simulated Xilinx designs.

## Interface
- `DATA_W`, 8: word width in bits, 1..64.
- `ADDR_W`, 5: address width; depth `DEPTH = 2**ADDR_W`, 2..256 words.
- `OUT_REG`, 0: 0 = asynchronous read (combinational `SPO`/`DPO`); 1 = registered read, 1-cycle latency.
- `WR_FIRST`, 0: only used when `OUT_REG=1`. On an address collision with an effective write, 1 returns the new data and 0 returns the old data.
- `INIT_VAL`, 0 (`DATA_W` bits): power-up and clear value of every word.

Ports:
- `CLK` in 1: single clock; all writes and registers on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `CLR` in 1: synchronous clear request, sampled on rising edge.
- `WE` in 1: write enable for port A.
- `A` in `ADDR_W`: read/write address, port A.
- `D` in `DATA_W`: write data.
- `DPRA` in `ADDR_W`: read address, port B.
- `SPO` out `DATA_W`: port A read data.
- `DPO` out `DATA_W`: port B read data.
- `BUSY` out 1: clear sweep in progress; user writes are ignored.
- `WE_DROP` out 1: registered 1-cycle pulse, set when a user write was discarded.

## Operation
- Storage: `DEPTH` x `DATA_W` array. Simulation power-up contents are `INIT_VAL` in every word.
- Effective user write: `WE & ~BUSY & ~CLR`, in state IDLE. On the edge, `mem[A] <= D`.
- Discarded write: `WE` asserted while `BUSY`, or `WE` together with `CLR`. `WE_DROP` is 1 on the following cycle. Memory is unchanged by the user write.
- FSM states are CLEAR and IDLE.
  - RST asserted: state=CLEAR, `clr_cnt`=0, `BUSY`=1, `WE_DROP`=0, registered `SPO`/`DPO`=0.
  - CLEAR, each edge: `mem[clr_cnt] <= INIT_VAL`, `clr_cnt` increments. On the edge where `clr_cnt == DEPTH-1`, the next state is IDLE and `BUSY` becomes 0.
  - IDLE with `CLR`=1: the next state is CLEAR with `clr_cnt`=0 and `BUSY`=1.
  - CLEAR with `CLR`=1: `clr_cnt` restarts at 0. The sweep restarts in full.
- Read paths:
  - `OUT_REG=0`: `SPO = mem[A]` and `DPO = mem[DPRA]`, combinational. During CLEAR they reflect partially cleared contents.
  - `OUT_REG=1`: each edge latches `mem[A]` into `SPO` and `mem[DPRA]` into `DPO`. On an effective write to the same address, the latched value is `D` if `WR_FIRST=1` and the old word otherwise. Registers update during CLEAR as well. The sweep write follows the same collision rule, with `INIT_VAL` in place of `D`.
- Address arithmetic is unsigned. `clr_cnt` is `ADDR_W` bits and wraps naturally, but the FSM leaves CLEAR before the wrap.

## Timing
- Write latency: data is visible on async `SPO` at the same `A` immediately after the write edge.
- Registered read latency is 1 cycle.
- Clear duration: `BUSY` stays high for exactly `DEPTH` rising edges after RST is deasserted or `CLR` is sampled. The first sweep edge writes address 0.
- `RST` asserted mid-sweep aborts the sweep. It restarts from 0 after release; words already cleared stay cleared.
- Reset values: `BUSY`=1, `WE_DROP`=0, and registered `SPO`/`DPO`=0. With `OUT_REG=0`, `SPO`/`DPO` show memory contents.

## Structure
- Package `ram_dist_pkg`: the FSM state enum (`ST_IDLE`, `ST_CLEAR`) and a depth/width localparam helper function.
- Sub-module `ram_dist_core`: a pure array with one synchronous write port and two asynchronous read ports, with no reset. The top level contains the FSM, the write mux (sweep vs. user), the collision bypass, and the output registers.

## Test plan
- Reset sweep: `ADDR_W=3`, `INIT_VAL=8'hA5`. Release RST → `BUSY` is high for 8 cycles, then low. All 8 words read `8'hA5` on `DPO`.
- Write/read: write `8'h3C` to A=5. With `OUT_REG=0`, `SPO` = `8'h3C` the same cycle after the edge and `DPO` (`DPRA`=5) = `8'h3C`. With `OUT_REG=1`, both appear one cycle later.
- Collision: `OUT_REG=1`, mem[2]=`8'h11`; write `8'h22` to A=2 with `DPRA`=2. `WR_FIRST=0` → `DPO`=`8'h11` at the next cycle; `WR_FIRST=1` → `8'h22`.
- Dropped writes: `WE`=1 during `BUSY`, or `WE`=1 with `CLR`=1 in IDLE → `WE_DROP` pulses once and the target word is unchanged.
- Clear restart: assert `CLR` at sweep count 4 → `BUSY` is high for a further 8 cycles from that edge. Then assert `RST` at count 3 → the sweep restarts at 0 after release.
- Wrap/boundary: `ADDR_W=3`, write addresses 7 and 0 back-to-back → both words are stored independently, and the FSM stays in IDLE.
